// File: rtl/apb_banked_mem.sv
// APB slave memory built from NUM_BANKS low-order-interleaved banks. It supports byte strobes,
// wait states, an error response on bad addresses, and a zero-fill sweep after reset.
module apb_banked_mem #(
   parameter int ADDR_WIDTH  = 13,
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_BANKS   = 4,
   parameter int BANK_DEPTH  = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [ADDR_WIDTH-1:0]   PADDR,
   input  logic [DATA_WIDTH-1:0]   PWDATA,
   input  logic [DATA_WIDTH/8-1:0] PSTRB,
   output logic [DATA_WIDTH-1:0]   PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR,
   output logic                    init_done
);
   localparam int BYTES  = DATA_WIDTH / 8;
   localparam int OFF_W  = $clog2(BYTES);
   localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int ROW_W  = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BYTES - 1);
   localparam logic [ADDR_WIDTH-1:0] NB       = ADDR_WIDTH'(NUM_BANKS);
   localparam logic [ADDR_WIDTH-1:0] ND       = ADDR_WIDTH'(BANK_DEPTH);
   localparam longint TOTAL_WORDS = longint'(NUM_BANKS) * longint'(BANK_DEPTH);

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_ACCESS} state_e;

   state_e                state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [ROW_W-1:0]      init_row_q, init_row_d;
   logic                  init_done_q, init_done_d;
   logic                  pready_q, pready_d;
   logic                  pslverr_q, pslverr_d;
   logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
   logic                  wr_q, wr_d;
   logic                  err_q, err_d;
   logic [BANK_W-1:0]     bank_q, bank_d;
   logic [ROW_W-1:0]      row_q, row_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [BYTES-1:0]      strb_q, strb_d;

   logic [ADDR_WIDTH-1:0] dec_word;
   logic [BANK_W-1:0]     dec_bank;
   logic [ROW_W-1:0]      dec_row;
   logic                  dec_err;
   logic                  init_we, rd_en, wr_commit;
   logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] rd_all;
   logic [DATA_WIDTH-1:0] rd_resp;

   always_comb begin
      dec_word = PADDR >> OFF_W;
      dec_bank = BANK_W'(dec_word % NB);
      dec_row  = ROW_W'((dec_word / NB) % ND);
      dec_err  = ((PADDR & OFF_MASK) != '0) || (longint'(dec_word) >= TOTAL_WORDS);
   end

   assign rd_resp = err_q ? '0 : rd_all[bank_q];

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      init_row_d  = init_row_q;
      init_done_d = init_done_q;
      pready_d    = 1'b0;
      pslverr_d   = 1'b0;
      prdata_d    = prdata_q;
      wr_d        = wr_q;
      err_d       = err_q;
      bank_d      = bank_q;
      row_d       = row_q;
      wdata_d     = wdata_q;
      strb_d      = strb_q;
      init_we     = 1'b0;
      rd_en       = 1'b0;
      wr_commit   = 1'b0;
      if (pready_q && !wr_q) prdata_d = rd_resp;
      case (state_q)
         ST_INIT: begin
            init_we    = 1'b1;
            init_row_d = init_row_q + ROW_W'(1);
            if (init_row_q == ROW_W'(BANK_DEPTH - 1)) begin
               state_d     = ST_IDLE;
               init_done_d = 1'b1;
            end
         end
         ST_IDLE: begin
            if (PSEL) begin
               wr_d      = PWRITE;
               err_d     = dec_err;
               bank_d    = dec_bank;
               row_d     = dec_row;
               wdata_d   = PWDATA;
               strb_d    = PSTRB;
               rd_en     = !PWRITE && !dec_err;
               cnt_d     = 3'(WAIT_STATES);
               pready_d  = (WAIT_STATES == 0);
               pslverr_d = (WAIT_STATES == 0) && dec_err;
               state_d   = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (!PSEL) begin
               state_d = ST_IDLE;
            end else if (cnt_q == 3'd0) begin
               // The write lands only while the master holds a genuine access phase.
               wr_commit = wr_q && !err_q && PENABLE;
               state_d   = ST_IDLE;
            end else begin
               cnt_d     = cnt_q - 3'd1;
               pready_d  = (cnt_q == 3'd1);
               pslverr_d = (cnt_q == 3'd1) && err_q;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignments, so each one samples values from before the edge.
      if (rst) begin
         state_q     <= ST_INIT;
         cnt_q       <= '0;
         init_row_q  <= '0;
         init_done_q <= 1'b0;
         pready_q    <= 1'b0;
         pslverr_q   <= 1'b0;
         prdata_q    <= '0;
         wr_q        <= 1'b0;
         err_q       <= 1'b0;
         bank_q      <= '0;
         row_q       <= '0;
         wdata_q     <= '0;
         strb_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         init_row_q  <= init_row_d;
         init_done_q <= init_done_d;
         pready_q    <= pready_d;
         pslverr_q   <= pslverr_d;
         prdata_q    <= prdata_d;
         wr_q        <= wr_d;
         err_q       <= err_d;
         bank_q      <= bank_d;
         row_q       <= row_d;
         wdata_q     <= wdata_d;
         strb_q      <= strb_d;
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];
      logic [DATA_WIDTH-1:0] rd_q;
      // NOTE: the storage array has no reset; the INIT sweep zero-fills it instead.
      always_ff @(posedge clk) begin
         if (!rst && init_we) begin
            mem[init_row_q] <= '0;
         end else if (!rst && wr_commit && bank_q == BANK_W'(b)) begin
            for (int i = 0; i < BYTES; i++) begin
               if (strb_q[i]) mem[row_q][i*8 +: 8] <= wdata_q[i*8 +: 8];
            end
         end
         if (rd_en && dec_bank == BANK_W'(b)) rd_q <= mem[dec_row];
      end
      assign rd_all[b] = rd_q;
   end

   assign PRDATA    = (pready_q && !wr_q) ? rd_resp : prdata_q;
   assign PREADY    = pready_q;
   assign PSLVERR   = pslverr_q;
   assign init_done = init_done_q;
endmodule

// File: tb/tb_apb_banked_mem.sv
// Scoreboard bench for apb_banked_mem. Two instances share one APB bus:
// u_ws0 has no wait states, u_ws3 has three.
module tb_apb_banked_mem;
   localparam int AW  = 13;
   localparam int DW  = 32;
   localparam int WS1 = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    psel = '0;
   logic          penable = 1'b0;
   logic          pwrite = 1'b0;
   logic [AW-1:0] paddr = '0;
   logic [DW-1:0] pwdata = '0;
   logic [3:0]    pstrb = '0;

   logic [DW-1:0] prdata0, prdata1;
   logic          pready0, pready1, pslverr0, pslverr1, idone0, idone1;
   logic [1:0][DW-1:0] prdata;
   logic [1:0]    pready, pslverr, idone;

   assign prdata  = {prdata1, prdata0};
   assign pready  = {pready1, pready0};
   assign pslverr = {pslverr1, pslverr0};
   assign idone   = {idone1, idone0};

   always #5 clk = ~clk;

   apb_banked_mem #(.WAIT_STATES(0)) u_ws0 (
      .clk(clk), .rst(rst), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata0),
      .PREADY(pready0), .PSLVERR(pslverr0), .init_done(idone0)
   );

   apb_banked_mem #(.WAIT_STATES(WS1)) u_ws3 (
      .clk(clk), .rst(rst), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata1),
      .PREADY(pready1), .PSLVERR(pslverr1), .init_done(idone1)
   );

   typedef struct {
      logic          err;
      logic [DW-1:0] rdata;
      int            lat;
   } exp_t;

   exp_t          sb_q[$];
   int            n_checks = 0;
   int            n_fail = 0;
   int            ws_tab[2] = '{0, WS1};
   logic [DW-1:0] model[2][1024];
   logic [DW-1:0] last_rd[2];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_model();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 1024; i++) model[d][i] = '0;
         last_rd[d] = '0;
      end
   endtask

   // Called at a falling edge; returns at a falling edge with the bus idle.
   task automatic do_reset(input logic wait_init);
      int cnt;
      rst = 1'b1;
      psel = '0;
      penable = 1'b0;
      @(negedge clk);
      check("rst/pready", 64'(pready), 64'(0));
      check("rst/pslverr", 64'(pslverr), 64'(0));
      check("rst/prdata", 64'(prdata), 64'(0));
      check("rst/init_done", 64'(idone), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      clear_model();
      if (wait_init) begin
         cnt = 1;
         while (!idone[0] && cnt < 1000) begin
            @(negedge clk);
            if (!idone[0]) cnt++;
         end
         check("init/cycles_low", 64'(cnt), 64'(256));
         check("init/done_both", 64'(idone), 64'(2'b11));
      end
   endtask

   task automatic apb_xfer(input int d, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [3:0] strb, input string tag);
      exp_t e, got_e;
      int   cyc, rdy_at;
      logic done, early;
      e.err = (addr[1:0] != 2'b00) || (addr >= 13'h1000);
      e.lat = 1 + ws_tab[d];
      if (wr) begin
         if (!e.err) begin
            for (int i = 0; i < 4; i++)
               if (strb[i]) model[d][addr[11:2]][i*8 +: 8] = wdata[i*8 +: 8];
         end
         e.rdata = last_rd[d];
      end else begin
         e.rdata = e.err ? '0 : model[d][addr[11:2]];
         last_rd[d] = e.rdata;
      end
      sb_q.push_back(e);

      psel = '0;
      psel[d] = 1'b1;
      penable = 1'b0;
      pwrite = wr;
      paddr = addr;
      pwdata = wdata;
      pstrb = strb;
      rdy_at = idone[d] ? 0 : -1;
      cyc = 0;
      done = 1'b0;
      early = 1'b0;
      while (!done && cyc < 1000) begin
         @(negedge clk);
         cyc++;
         penable = 1'b1;
         if (pready[d] && !idone[d]) early = 1'b1;
         if (rdy_at < 0 && idone[d]) rdy_at = cyc;
         if (pready[d]) done = 1'b1;
      end
      check({tag, "/completed"}, 64'(done), 64'(1));
      got_e = sb_q.pop_front();
      if (done) begin
         check({tag, "/latency"}, 64'(cyc - rdy_at), 64'(got_e.lat));
         check({tag, "/pslverr"}, 64'(pslverr[d]), 64'(got_e.err));
         check({tag, "/prdata"}, 64'(prdata[d]), 64'(got_e.rdata));
      end
      check({tag, "/pready_before_init"}, 64'(early), 64'(0));
      @(negedge clk);
      if (done) check({tag, "/pready_one_cycle"}, 64'(pready[d]), 64'(0));
      psel = '0;
      penable = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      do_reset(1'b1);

      apb_xfer(0, 1'b0, 13'h0FFC, '0, 4'h0, "rd_ffc_zero");
      apb_xfer(0, 1'b1, 13'h0010, 32'hDEADBEEF, 4'hF, "wr_010");
      apb_xfer(0, 1'b0, 13'h0010, '0, 4'h0, "rd_010");

      apb_xfer(0, 1'b1, 13'h0000, 32'h11223344, 4'hF, "wr_bank0");
      apb_xfer(0, 1'b1, 13'h0004, 32'h55667788, 4'hF, "wr_bank1");
      apb_xfer(0, 1'b1, 13'h0008, 32'h99AABBCC, 4'hF, "wr_bank2");
      apb_xfer(0, 1'b1, 13'h000C, 32'h0F1E2D3C, 4'hF, "wr_bank3");
      apb_xfer(0, 1'b0, 13'h0000, '0, 4'h0, "rd_bank0");
      apb_xfer(0, 1'b0, 13'h0004, '0, 4'h0, "rd_bank1");
      apb_xfer(0, 1'b0, 13'h0008, '0, 4'h0, "rd_bank2");
      apb_xfer(0, 1'b0, 13'h000C, '0, 4'h0, "rd_bank3");
      apb_xfer(0, 1'b1, 13'h0000, 32'hAABBCCDD, 4'h5, "wr_strb5");
      apb_xfer(0, 1'b0, 13'h0000, '0, 4'h0, "rd_merged");
      apb_xfer(0, 1'b1, 13'h0004, 32'hFFFFFFFF, 4'h0, "wr_strb0_noop");
      apb_xfer(0, 1'b0, 13'h0004, '0, 4'h0, "rd_after_noop");

      apb_xfer(0, 1'b1, 13'h0001, 32'h12345678, 4'hF, "wr_misaligned");
      apb_xfer(0, 1'b0, 13'h0000, '0, 4'h0, "rd_after_err_wr");
      apb_xfer(0, 1'b0, 13'h1000, '0, 4'h0, "rd_out_of_range");
      apb_xfer(0, 1'b0, 13'h1FFE, '0, 4'h0, "rd_oor_misaligned");
      apb_xfer(0, 1'b0, 13'h0008, '0, 4'h0, "rd_okay_after_err");

      apb_xfer(1, 1'b1, 13'h0FFC, 32'hA5A55A5A, 4'hF, "ws3_wr_ffc");
      apb_xfer(1, 1'b0, 13'h0FFC, '0, 4'h0, "ws3_rd_ffc");
      apb_xfer(1, 1'b1, 13'h0FFC, 32'h00C0FFEE, 4'hA, "ws3_wr_strbA");
      apb_xfer(1, 1'b0, 13'h0FFC, '0, 4'h0, "ws3_rd_strbA");
      apb_xfer(1, 1'b0, 13'h1004, '0, 4'h0, "ws3_rd_oor");

      for (int k = 0; k < 24; k++) begin
         int            d;
         logic [AW-1:0] a;
         logic [3:0]    s;
         d = int'($urandom_range(0, 1));
         a = AW'({$urandom_range(0, 15), 2'b00});
         if (k % 8 == 7) a[0] = 1'b1;
         s = 4'($urandom_range(0, 15));
         apb_xfer(d, 1'($urandom_range(0, 1)), a, $urandom(), s, "rand");
      end

      do_reset(1'b0);
      repeat (10) @(negedge clk);
      apb_xfer(1, 1'b0, 13'h0010, '0, 4'h0, "ws3_rd_during_init");

      apb_xfer(1, 1'b1, 13'h0020, 32'h12345678, 4'hF, "ws3_pre_wr_020");
      apb_xfer(1, 1'b0, 13'h0020, '0, 4'h0, "ws3_pre_rd_020");
      psel = '0;
      psel[1] = 1'b1;
      pwrite = 1'b1;
      paddr = 13'h0020;
      pwdata = 32'hCAFEF00D;
      pstrb = 4'hF;
      penable = 1'b0;
      @(negedge clk);
      penable = 1'b1;
      check("midrst/pready_in_access", 64'(pready[1]), 64'(0));
      do_reset(1'b1);
      apb_xfer(1, 1'b0, 13'h0020, '0, 4'h0, "ws3_rd_020_after_rst");

      check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
